// File: rtl/serial_subtractor4.sv
// rtl/serial_subtractor4.sv - 4-bit bit-serial subtractor with borrow chaining and signed overflow

// One-bit full subtractor: x - y - bi -> diff with borrow-out bo.
module serial_subtractor4_fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  // Borrow is generated when y exceeds x, or propagated when x == y.
  always_comb begin
    diff = x ^ y ^ bi;
    bo   = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// Computes {bout,d} = a - b - bin one bit per clock, LSB first.
// start in IDLE captures the operands; four SHIFT cycles follow; DONE
// presents the one-cycle done pulse and then returns to IDLE.
module serial_subtractor4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       ovf,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;

  // Operand shift registers; bit 0 is the bit being processed this cycle.
  logic [3:0] a_sr;
  logic [3:0] b_sr;

  // Difference bits 0..2 collect here MSB-first so that on the final bit
  // the full result is {bit3_diff, diff_sr} with no further shifting.
  logic [2:0] diff_sr;

  // Single borrow flop carried between bit cycles.
  logic       br;

  // Bit index; wrapping 3 -> 0 marks the last bit.
  logic [1:0] cnt;

  logic       bit_diff;
  logic       bit_bo;
  logic       last_bit;

  serial_subtractor4_fs u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bi   (br),
    .diff (bit_diff),
    .bo   (bit_bo)
  );

  // The final bit is the one where the counter is about to wrap.
  always_comb begin
    last_bit = (cnt == 2'd3);
  end

  // Control FSM, datapath shifting and registered outputs in one process so
  // that d/bout/ovf can only change on the DONE-entry edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_sr    <= 4'd0;
      b_sr    <= 4'd0;
      diff_sr <= 3'd0;
      br      <= 1'b0;
      cnt     <= 2'd0;
      d       <= 4'd0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            br      <= bin;
            cnt     <= 2'd0;
            diff_sr <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr    <= {1'b0, a_sr[3:1]};
          b_sr    <= {1'b0, b_sr[3:1]};
          br      <= bit_bo;
          diff_sr <= {bit_diff, diff_sr[2:1]};
          cnt     <= cnt + 2'd1;
          if (last_bit) begin
            // a_sr[0]/b_sr[0] hold the latched sign bits on this cycle.
            d     <= {bit_diff, diff_sr};
            bout  <= bit_bo;
            ovf   <= (a_sr[0] ^ b_sr[0]) & (bit_diff ^ a_sr[0]);
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
